// File: rtl/z_mem_stage_if.sv
// z_mem_stage_if: upstream, memory and writeback signals of the memory stage.
// The master side drives the ALU result and memory response; the slave side is the stage itself.
interface z_mem_stage_if;
   logic        in_valid, in_ready, alu_zero;
   logic [31:0] alu_out, ins_in, store_data, pc_plus4;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        wb_valid, wb_we, mem_err, branch_taken;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, branch_target;
   modport master (
      output in_valid, alu_out, alu_zero, ins_in, store_data, pc_plus4, mem_ack, mem_rdata,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_we, wb_rd, wb_data,
             mem_err, branch_taken, branch_target
   );
   modport slave (
      input  in_valid, alu_out, alu_zero, ins_in, store_data, pc_plus4, mem_ack, mem_rdata,
      output in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_we, wb_rd, wb_data,
             mem_err, branch_taken, branch_target
   );
endinterface

// File: rtl/z_mem_stage.sv
// z_mem_stage: MIPS-style memory stage (IDLE -> [MEM_WAIT] -> WB) with ack timeout.
// Define Z_BRANCH_RESOLVE_EN to resolve beq/bne branches in the WB cycle.
module z_mem_stage #(
   parameter int ACK_TIMEOUT = 15
) (
   input logic clk,
   input logic rst,
   z_mem_stage_if.slave m
);
   typedef enum logic [1:0] {IDLE, MEM_WAIT, WB} state_t;
   state_t      state, state_nx;
   logic [31:0] ins_r, alu_r, sdata_r, pc4_r;
   logic        zero_r, err_r;
   logic [7:0]  cnt;
   logic [5:0]  op;
   logic [4:0]  dest;
   logic        accept, in_mem, in_align, timeout, is_lw, is_sw, is_r, has_dest, unused_ok;
   assign accept   = m.in_valid && m.in_ready;
   assign in_mem   = m.ins_in[31:26] == 6'b100011 || m.ins_in[31:26] == 6'b101011;
   assign in_align = m.alu_out[1:0] == 2'b00;
   assign op       = ins_r[31:26];
   assign is_lw    = op == 6'b100011;
   assign is_sw    = op == 6'b101011;
   assign is_r     = op == 6'b000000;
   assign has_dest = (is_r && ins_r[5:0] inside {6'b100001, 6'b100011, 6'b101111, 6'b000000, 6'b000010})
                  || op == 6'b001001 || op == 6'b001100 || is_lw;
   assign dest     = has_dest ? (is_r ? ins_r[15:11] : ins_r[20:16]) : 5'd0;
   // An ack in the final allowed wait cycle wins over the timeout.
   assign timeout  = state == MEM_WAIT && !m.mem_ack && cnt + 8'd1 == 8'(ACK_TIMEOUT);
   assign unused_ok = ^{ins_r, zero_r, pc4_r};
   always_comb begin
      state_nx = state == IDLE     ? (accept ? (in_mem && in_align ? MEM_WAIT : WB) : IDLE)
               : state == MEM_WAIT ? (m.mem_ack || timeout ? WB : MEM_WAIT)
               : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ins_r   <= '0;
         alu_r   <= '0;
         sdata_r <= '0;
         pc4_r   <= '0;
         zero_r  <= 1'b0;
         err_r   <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            ins_r   <= m.ins_in;
            alu_r   <= m.alu_out;
            sdata_r <= m.store_data;
            pc4_r   <= m.pc_plus4;
            zero_r  <= m.alu_zero;
            err_r   <= in_mem && !in_align;
            cnt     <= '0;
         end
         if (state == MEM_WAIT) begin
            if (m.mem_ack) begin
               if (is_lw) alu_r <= m.mem_rdata;
            end else begin
               cnt <= cnt + 8'd1;
               if (timeout) err_r <= 1'b1;
            end
         end
      end
   end
   assign m.in_ready  = state == IDLE;
   assign m.mem_req   = state == MEM_WAIT;
   assign m.mem_we    = m.mem_req && is_sw;
   assign m.mem_addr  = m.mem_req ? alu_r : '0;
   assign m.mem_wdata = m.mem_req ? sdata_r : '0;
   assign m.wb_valid  = state == WB;
   assign m.wb_we     = m.wb_valid && !err_r && dest != 5'd0;
   assign m.wb_rd     = m.wb_valid ? dest : '0;
   assign m.wb_data   = m.wb_valid ? alu_r : '0;
   assign m.mem_err   = m.wb_valid && err_r;
`ifdef Z_BRANCH_RESOLVE_EN
   logic is_br;
   assign is_br           = op == 6'b000100 || op == 6'b000101;
   assign m.branch_taken  = m.wb_valid && is_br && zero_r;
   assign m.branch_target = m.branch_taken ? pc4_r + {{14{ins_r[15]}}, ins_r[15:0], 2'b00} : '0;
`else
   assign m.branch_taken  = 1'b0;
   assign m.branch_target = '0;
`endif
endmodule

// File: tb/tb_z_mem_stage.sv
// tb_z_mem_stage: directed vector table for single-cycle instructions plus
// hand sequences for load/store waits, timeout, late ack and mid-access reset.
module tb_z_mem_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   z_mem_stage_if bus();
   z_mem_stage #(.ACK_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .m(bus.slave));
   int n_chk = 0;
   int n_fail = 0;
`ifdef Z_BRANCH_RESOLVE_EN
   localparam bit BR = 1'b1;
`else
   localparam bit BR = 1'b0;
`endif
   typedef struct {
      logic [31:0] ins, alu;
      logic        zero;
      logic [31:0] pc4;
      logic        we;
      logic [4:0]  rd;
      logic        err, bt;
      logic [31:0] btgt;
   } vec_t;
   vec_t vecs[12];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic zero,
                        input logic [31:0] sd, input logic [31:0] pc4);
      bus.in_valid   = 1'b1;
      bus.ins_in     = ins;
      bus.alu_out    = alu;
      bus.alu_zero   = zero;
      bus.store_data = sd;
      bus.pc_plus4   = pc4;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic chk_all_zero(input string name);
      chk({name, "_outs"}, 32'(|{bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wb_valid,
                                 bus.wb_we, bus.wb_rd, bus.wb_data, bus.mem_err, bus.branch_taken,
                                 bus.branch_target}), 32'd0);
      chk({name, "_ready"}, 32'(bus.in_ready), 32'd1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      vecs = '{
         '{32'h00221821, 32'h00000005, 1'b0, 32'h0,   1'b1, 5'd3,  1'b0, 1'b0, 32'h0},
         '{32'h24000007, 32'h00000007, 1'b0, 32'h0,   1'b0, 5'd0,  1'b0, 1'b0, 32'h0},
         '{32'h3045000F, 32'h0000000A, 1'b0, 32'h0,   1'b1, 5'd5,  1'b0, 1'b0, 32'h0},
         '{32'h00852020, 32'h00000099, 1'b0, 32'h0,   1'b0, 5'd0,  1'b0, 1'b0, 32'h0},
         '{32'hAC080000, 32'h00000102, 1'b0, 32'h0,   1'b0, 5'd0,  1'b1, 1'b0, 32'h0},
         '{32'h8C080000, 32'h00000101, 1'b0, 32'h0,   1'b0, 5'd8,  1'b1, 1'b0, 32'h0},
         '{32'h1000FFFF, 32'h00000000, 1'b1, 32'h40,  1'b0, 5'd0,  1'b0, BR,   BR ? 32'h3C : 32'h0},
         '{32'h1000FFFF, 32'h00000004, 1'b0, 32'h40,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0},
         '{32'h14000004, 32'h00000001, 1'b1, 32'h100, 1'b0, 5'd0,  1'b0, BR,   BR ? 32'h110 : 32'h0},
         '{32'h08000000, 32'h12345678, 1'b1, 32'h0,   1'b0, 5'd0,  1'b0, 1'b0, 32'h0},
         '{32'h00000000, 32'h00000000, 1'b0, 32'h0,   1'b0, 5'd0,  1'b0, 1'b0, 32'h0},
         '{32'h0000F823, 32'hFFFFFFF0, 1'b0, 32'h0,   1'b1, 5'd31, 1'b0, 1'b0, 32'h0}
      };
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.ins_in = '0; bus.alu_out = '0; bus.alu_zero = 1'b0;
      bus.store_data = '0; bus.pc_plus4 = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("reset");
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].ins, vecs[i].alu, vecs[i].zero, 32'hA5A5A5A5, vecs[i].pc4);
         chk($sformatf("v%0d_wb_valid", i), 32'(bus.wb_valid), 32'd1);
         chk($sformatf("v%0d_wb_we", i), 32'(bus.wb_we), 32'(vecs[i].we));
         chk($sformatf("v%0d_wb_rd", i), 32'(bus.wb_rd), 32'(vecs[i].rd));
         chk($sformatf("v%0d_wb_data", i), bus.wb_data, vecs[i].alu);
         chk($sformatf("v%0d_mem_err", i), 32'(bus.mem_err), 32'(vecs[i].err));
         chk($sformatf("v%0d_br_taken", i), 32'(bus.branch_taken), 32'(vecs[i].bt));
         chk($sformatf("v%0d_br_target", i), bus.branch_target, vecs[i].btgt);
         chk($sformatf("v%0d_mem_req", i), 32'(bus.mem_req), 32'd0);
         chk($sformatf("v%0d_ready_wb", i), 32'(bus.in_ready), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_wb_drop", i), 32'(bus.wb_valid), 32'd0);
         chk($sformatf("v%0d_ready_idle", i), 32'(bus.in_ready), 32'd1);
      end
      // lw acknowledged on the fourth wait cycle
      issue(32'h8C080000, 32'h100, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("lw_req_c%0d", k), 32'(bus.mem_req), 32'd1);
         chk($sformatf("lw_addr_c%0d", k), bus.mem_addr, 32'h100);
         chk($sformatf("lw_we_c%0d", k), 32'(bus.mem_we), 32'd0);
         chk($sformatf("lw_ready_c%0d", k), 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      chk("lw_req_c3", 32'(bus.mem_req), 32'd1);
      chk("lw_addr_c3", bus.mem_addr, 32'h100);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      chk("lw_req_drop", 32'(bus.mem_req), 32'd0);
      chk("lw_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("lw_wb_data", bus.wb_data, 32'hDEADBEEF);
      chk("lw_wb_rd", 32'(bus.wb_rd), 32'd8);
      chk("lw_wb_we", 32'(bus.wb_we), 32'd1);
      chk("lw_err", 32'(bus.mem_err), 32'd0);
      // stray ack while not waiting
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11111111;
      @(negedge clk);
      chk("stray_ready", 32'(bus.in_ready), 32'd1);
      chk("stray_req", 32'(bus.mem_req), 32'd0);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk_all_zero("stray_idle");
      // sw acknowledged immediately
      issue(32'hAC090000, 32'h200, 1'b0, 32'h12345678, 32'h0);
      chk("sw_req", 32'(bus.mem_req), 32'd1);
      chk("sw_we", 32'(bus.mem_we), 32'd1);
      chk("sw_addr", bus.mem_addr, 32'h200);
      chk("sw_wdata", bus.mem_wdata, 32'h12345678);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("sw_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("sw_wb_we", 32'(bus.wb_we), 32'd0);
      chk("sw_err", 32'(bus.mem_err), 32'd0);
      chk("sw_req_drop", 32'(bus.mem_req), 32'd0);
      @(negedge clk);
      // lw with no ack: timeout after ACK_TIMEOUT wait cycles
      issue(32'h8C080000, 32'h104, 1'b0, 32'h0, 32'h0);
      n = 0;
      while (bus.mem_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("to_req_cycles", 32'(n), 32'd15);
      chk("to_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("to_err", 32'(bus.mem_err), 32'd1);
      chk("to_wb_we", 32'(bus.wb_we), 32'd0);
      @(negedge clk);
      chk("to_err_pulse", 32'(bus.mem_err), 32'd0);
      // ack in the last allowed wait cycle counts as success
      issue(32'h8C090000, 32'h108, 1'b0, 32'h0, 32'h0);
      repeat (14) @(negedge clk);
      chk("late_req", 32'(bus.mem_req), 32'd1);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      chk("late_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("late_err", 32'(bus.mem_err), 32'd0);
      chk("late_wb_we", 32'(bus.wb_we), 32'd1);
      chk("late_wb_data", bus.wb_data, 32'hCAFEF00D);
      chk("late_wb_rd", 32'(bus.wb_rd), 32'd9);
      @(negedge clk);
      // reset in the middle of a memory wait
      issue(32'h8C080000, 32'h10C, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rstw_req", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("rstw");
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk_all_zero("rstw_late_ack");
      @(negedge clk);
      chk_all_zero("rstw_after");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/z_mem_stage.md
Z_MEM_STAGE -- requirements
Module: z_mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles waiting for mem_ack (1..255) SHALL be supported.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 in_valid  input  1  upstream ALU result valid.
REQ-005 in_ready  output  1  stage can accept; SHALL equal (state==IDLE).
REQ-006 alu_out  input  32  ALU result (data or memory address).
REQ-007 alu_zero  input  1  ALU zero flag.
REQ-008 ins_in  input  32  instruction paired with alu_out.
REQ-009 store_data  input  32  rt value for sw.
REQ-010 pc_plus4  input  32  PC+4 of the instruction.
REQ-011 mem_req / mem_we  output  1 / 1  memory request strobe / write enable.
REQ-012 mem_addr / mem_wdata  output  32 / 32  word address, store data.
REQ-013 mem_ack / mem_rdata  input  1 / 32  memory completion, load data (valid with ack).
REQ-014 wb_valid / wb_we / wb_rd / wb_data  output  1 / 1 / 5 / 32  writeback pulse, enable, dest reg, value.
REQ-015 mem_err  output  1  one-cycle pulse on misalignment or ack timeout.
REQ-016 branch_taken / branch_target  output  1 / 32  branch resolution (see REQ-031).

Function
REQ-017 Accept SHALL occur on rising edge with in_valid && in_ready; ins_in, alu_out, alu_zero, store_data, pc_plus4 SHALL be latched.
REQ-018 States SHALL be IDLE, MEM_WAIT, WB; reset state IDLE.
REQ-019 Decode by ins_in[31:26]: 000000 R-type (dest ins[15:11], writes only for funct 100001,100011,101111,000000,000010); 001001 addiu, 001100 andi (dest ins[20:16]); 100011 lw (dest ins[20:16], read); 101011 sw (write, no dest); 000100 beq, 000101 bne (no dest); all others no-op.
REQ-020 Non-memory accept: IDLE->WB; wb_valid SHALL pulse the cycle after accept with wb_data=latched alu_out.
REQ-021 lw/sw accept with alu_out[1:0]==0: IDLE->MEM_WAIT; mem_req=1 from next cycle, held with constant mem_addr/mem_we/mem_wdata until the cycle mem_ack=1.
REQ-022 On mem_ack: mem_req SHALL drop next cycle; lw -> WB with wb_data=mem_rdata captured at ack; sw -> WB with wb_we=0.
REQ-023 lw/sw with alu_out[1:0]!=0: no memory request; IDLE->WB, mem_err pulse concurrent with wb_valid, wb_we=0.
REQ-024 Timeout: 8-bit counter cleared on MEM_WAIT entry, increments each MEM_WAIT cycle without ack; when it reaches ACK_TIMEOUT without ack -> WB with wb_we=0, mem_err pulse with wb_valid, mem_req drops.
REQ-025 Ack in the same cycle the counter reaches ACK_TIMEOUT SHALL count as success.
REQ-026 WB lasts exactly one cycle, then IDLE; wb_valid SHALL be 1 only in WB; no downstream back-pressure.
REQ-027 wb_we SHALL be 0 whenever dest reg is 0 or instruction has no dest.
REQ-028 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-029 Throughput: max one instruction per 2 cycles (accept, WB); in_ready low in MEM_WAIT and WB.

Reset
REQ-030 rst SHALL force IDLE and at the next edge zero every output except in_ready (=1); counter cleared; rst mid-MEM_WAIT abandons the access (mem_req=0 next cycle, late ack ignored).

Configuration
REQ-031 Macro Z_BRANCH_RESOLVE_EN defined: for beq and bne, branch_taken SHALL pulse with wb_valid when latched alu_zero==1 (ALU encodes bne so zero=1 means not-equal), branch_target=pc_plus4+(sign-extended ins[15:0]<<2), else 0/0; undefined: branch_taken and branch_target SHALL be constant 0.

Verification
REQ-032 addu ins 0x00221821, alu_out 0x5 -> wb_valid cycle after accept, wb_rd=3, wb_we=1, wb_data=0x5.
REQ-033 lw rt=8, alu_out 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF -> mem_req held 3+1 cycles, addr 0x100, then wb_data=0xDEADBEEF, wb_rd=8.
REQ-034 sw alu_out 0x102 -> no mem_req, mem_err and wb_valid pulse together, wb_we=0.
REQ-035 lw, mem_ack never, ACK_TIMEOUT=15 -> mem_req deasserts after 15 cycles, mem_err=1, wb_we=0.
REQ-036 Z_BRANCH_RESOLVE_EN, beq imm 0xFFFF, pc_plus4 0x40, zero=1 -> branch_taken=1, target 0x3C; rst asserted mid-MEM_WAIT -> all outputs 0, late ack ignored.
